// File: rtl/ibex_counter_ctrl_pkg.sv
// Shared types and width helpers for the performance-counter controller.
package ibex_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_COUNT   = 2'd0,
    SEL_EVTSEL  = 2'd1,
    SEL_INHIBIT = 2'd2,
    SEL_OVF     = 2'd3
  } ctr_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ctr_state_e;

  localparam int unsigned NumEventsDefault = 16;

  // Event-select width; a single-event bus still needs a 1-bit selector.
  function automatic int unsigned evt_sel_width(int unsigned num_events);
    return (num_events > 1) ? $clog2(num_events) : 1;
  endfunction

  localparam int unsigned EvtSelW = evt_sel_width(NumEventsDefault);

endpackage

// File: rtl/ibex_counter_evt_gate.sv
// Per-counter event select, inhibit and write gating, plus overflow detection.
module ibex_counter_evt_gate
  import ibex_counter_ctrl_pkg::*;
#(
  parameter int unsigned NumEvents    = NumEventsDefault,
  parameter int unsigned SelW         = evt_sel_width(NumEvents),
  parameter int unsigned CounterWidth = 40,
  parameter bit          IsCycle      = 1'b0
) (
  input  logic [NumEvents-1:0]    evt_i,
  input  logic [SelW-1:0]         evtsel_i,
  input  logic                    inhibit_i,
  input  logic                    wr_strobe_i,
  input  logic [CounterWidth-1:0] cnt_val_i,
  output logic                    inc_o,
  output logic                    ovf_o
);

  logic evt_sel;
  logic evt_hit;

  // Selector values beyond the event bus match nothing and never count.
  always_comb begin
    evt_sel = 1'b0;
    for (int unsigned j = 0; j < NumEvents; j++) begin
      if (evtsel_i == SelW'(j)) begin
        evt_sel = evt_i[j];
      end
    end
  end

  assign evt_hit = IsCycle ? evt_i[0] : evt_sel;
  assign inc_o   = evt_hit & ~inhibit_i & ~wr_strobe_i;
  assign ovf_o   = inc_o & (&cnt_val_i);

endmodule

// File: rtl/ibex_counter_ctrl.sv
// Performance-counter bank controller: request FSM, config/status registers and read mux.
module ibex_counter_ctrl
  import ibex_counter_ctrl_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned NumEvents    = NumEventsDefault,
  parameter int unsigned CounterWidth = 40
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [1:0]                sel_i,
  input  logic [4:0]                idx_i,
  input  logic                      hi_i,
  input  logic [31:0]               wdata_i,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  input  logic [NumEvents-1:0]      evt_i,
  input  logic [NumCounters*64-1:0] cnt_val_i,
  output logic [NumCounters-1:0]    cnt_inc_o,
  output logic [NumCounters-1:0]    cnt_we_o,
  output logic [NumCounters-1:0]    cnt_weh_o,
  output logic [31:0]               cnt_wdata_o,
  output logic                      ovf_irq_o
);

  localparam int unsigned SelW = evt_sel_width(NumEvents);

  ctr_state_e state_q, state_d;

  logic        we_q;
  ctr_sel_e    sel_q;
  logic [4:0]  idx_q;
  logic        hi_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;

  logic [SelW-1:0]        evtsel_q [NumCounters];
  logic [SelW-1:0]        evtsel_d [NumCounters];
  logic [NumCounters-1:0] inhibit_q, inhibit_d;
  logic [NumCounters-1:0] ovf_q, ovf_d, ovf_set, ovf_clr;
  logic [NumCounters-1:0] idx_dec, wr_strobe;
  logic                   ovf_irq_q;
  logic                   exec_wr;

  // Out-of-range indices decode to no counter at all.
  always_comb begin
    idx_dec = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      idx_dec[i] = (idx_q == 5'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_i) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign exec_wr = (state_q == ST_EXEC) & we_q;

  always_comb begin
    cnt_we_o  = '0;
    cnt_weh_o = '0;
    if (exec_wr && (sel_q == SEL_COUNT)) begin
      if (hi_q) begin
        cnt_weh_o = idx_dec;
      end else begin
        cnt_we_o = idx_dec;
      end
    end
  end

  assign wr_strobe = cnt_we_o | cnt_weh_o;

  for (genvar i = 0; i < NumCounters; i++) begin : g_gate
    ibex_counter_evt_gate #(
      .NumEvents   (NumEvents),
      .SelW        (SelW),
      .CounterWidth(CounterWidth),
      .IsCycle     (i == 0)
    ) u_gate (
      .evt_i      (evt_i),
      .evtsel_i   (evtsel_q[i]),
      .inhibit_i  (inhibit_q[i]),
      .wr_strobe_i(wr_strobe[i]),
      .cnt_val_i  (cnt_val_i[64*i +: CounterWidth]),
      .inc_o      (cnt_inc_o[i]),
      .ovf_o      (ovf_set[i])
    );
  end

  always_comb begin
    evtsel_d  = evtsel_q;
    inhibit_d = inhibit_q;
    ovf_clr   = '0;
    rdata_d   = rdata_q;
    if (state_q == ST_EXEC) begin
      rdata_d = '0;
      unique case (sel_q)
        SEL_COUNT: begin
          for (int unsigned i = 0; i < NumCounters; i++) begin
            if (!we_q && idx_dec[i]) begin
              rdata_d = hi_q ? cnt_val_i[64*i+32 +: 32] : cnt_val_i[64*i +: 32];
            end
          end
        end
        SEL_EVTSEL: begin
          for (int unsigned i = 0; i < NumCounters; i++) begin
            if (idx_dec[i]) begin
              if (we_q) begin
                evtsel_d[i] = wdata_q[SelW-1:0];
              end else begin
                rdata_d = 32'(evtsel_q[i]);
              end
            end
          end
        end
        SEL_INHIBIT: begin
          if (we_q) inhibit_d = wdata_q[NumCounters-1:0];
          else      rdata_d   = 32'(inhibit_q);
        end
        SEL_OVF: begin
          if (we_q) ovf_clr = wdata_q[NumCounters-1:0];
          else      rdata_d = 32'(ovf_q);
        end
        default: ;
      endcase
    end
  end

  // A fresh overflow beats a simultaneous W1C of the same bit.
  assign ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      sel_q     <= SEL_COUNT;
      idx_q     <= '0;
      hi_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      inhibit_q <= '0;
      ovf_q     <= '0;
      ovf_irq_q <= 1'b0;
      for (int unsigned i = 0; i < NumCounters; i++) begin
        evtsel_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      ovf_irq_q <= |ovf_q;
      evtsel_q  <= evtsel_d;
      if (req_i && gnt_o) begin
        we_q    <= we_i;
        sel_q   <= ctr_sel_e'(sel_i);
        idx_q   <= idx_i;
        hi_q    <= hi_i;
        wdata_q <= wdata_i;
      end
    end
  end

  assign gnt_o       = (state_q == ST_IDLE);
  assign rvalid_o    = (state_q == ST_RESP);
  assign rdata_o     = (state_q == ST_RESP) ? rdata_q : '0;
  assign cnt_wdata_o = wdata_q;
  assign ovf_irq_o   = ovf_irq_q;

endmodule
